// File: rtl/fetch_unit.sv
// Instruction-fetch stage: a single-outstanding-read fetch FSM feeding a DEPTH-entry prefetch queue.
// Redirects flush the queue; a read that is in flight when a redirect arrives is dropped when its ack returns.
//
// Handshakes: mem_req stays high with a stable mem_addr until mem_ack. The out_* head transfers on a cycle
// where out_valid and out_ready are both high. out_valid depends only on registered state.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 24,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 24'hFFE000
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      mem_req,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    input  logic                      redirect,
    input  logic [ADDR_WIDTH-1:0]     redirect_addr,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_instr,
    output logic [ADDR_WIDTH-1:0]     out_pc,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic [1:0]                state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] fpc;
    logic [ADDR_WIDTH-1:0] redir_aligned;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic                  push;
    logic                  pop;
    logic [LW-1:0]         next_level;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    logic [DATA_WIDTH-1:0] instr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q    [DEPTH];

    assign redir_aligned = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
    assign addr_inc      = mem_addr + ADDR_WIDTH'(4);

    assign push       = (state == S_WAIT) && mem_ack && !redirect;
    assign pop        = out_valid && out_ready && !redirect;
    assign next_level = level + LW'(push) - LW'(pop);

    assign mem_req   = (state != S_IDLE);
    assign out_valid = (level != '0);
    assign out_instr = instr_q[rd_ptr];
    assign out_pc    = pc_q[rd_ptr];
    assign state_dbg = state;

    // Queue storage carries no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr] <= mem_data;
            pc_q[wr_ptr]    <= mem_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (redirect) begin
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            level <= next_level;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // A new read is only issued while a queue slot is free, so an ack can always be pushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            mem_addr <= START_ADDR;
            fpc      <= START_ADDR;
        end else begin
            case (state)
                S_IDLE: begin
                    if (redirect) begin
                        fpc <= redir_aligned;
                    end else if (next_level < DEPTH_L) begin
                        state    <= S_WAIT;
                        mem_addr <= fpc;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        fpc   <= redir_aligned;
                        state <= mem_ack ? S_IDLE : S_DROP;
                    end else if (mem_ack) begin
                        fpc <= addr_inc;
                        if (next_level < DEPTH_L) mem_addr <= addr_inc;
                        else                      state    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (redirect) fpc   <= redir_aligned;
                    if (mem_ack)  state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors and hand-written multi-cycle sequences.
// The memory model returns {8'hC3, addr} after a programmable number of wait cycles.
module tb_fetch_unit;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready;
  logic [2:0]    level;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wait_cnt = 0;

  typedef struct {
    logic          rst;
    logic          redir;
    logic [AW-1:0] raddr;
    logic          rdy;
    logic          req;
    logic [AW-1:0] addr;
    logic [2:0]    lvl;
    logic          chk_pc;
    logic [AW-1:0] pc;
    logic [1:0]    st;
  } vec_t;

  vec_t vq[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {8'hC3, a};
  endfunction

  // clock / reset block
  always #5 clk = ~clk;

  // memory model
  assign mem_ack  = mem_req && (wait_cnt >= lat);
  assign mem_data = mem_word(mem_addr);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .START_ADDR(24'hFFE000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_data(mem_data),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .out_valid(out_valid),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_ready(out_ready),
    .level(level),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic rd, input logic [AW-1:0] ra, input logic rdy,
                         input logic req, input logic [AW-1:0] addr, input logic [2:0] lvl,
                         input logic cp, input logic [AW-1:0] pc, input logic [1:0] st);
    vec_t v;
    v.rst = r; v.redir = rd; v.raddr = ra; v.rdy = rdy;
    v.req = req; v.addr = addr; v.lvl = lvl; v.chk_pc = cp; v.pc = pc; v.st = st;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_addr = '0;
    out_ready = 1'b0;

    //      rst   redir raddr       rdy   | req   addr        lvl   chk   pc          state
    // streaming with zero-wait memory
    add_vec(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'hFFE000, 3'd0, 1'b0, 24'h000000, ST_IDLE);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hFFE000, 3'd0, 1'b0, 24'h000000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hFFE004, 3'd1, 1'b1, 24'hFFE000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hFFE008, 3'd1, 1'b1, 24'hFFE004, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hFFE00C, 3'd1, 1'b1, 24'hFFE008, ST_WAIT);
    // fill with decode stalled, then a single pop
    add_vec(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'hFFE000, 3'd0, 1'b0, 24'h000000, ST_IDLE);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hFFE000, 3'd0, 1'b0, 24'h000000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hFFE004, 3'd1, 1'b1, 24'hFFE000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hFFE008, 3'd2, 1'b1, 24'hFFE000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 24'hFFE00C, 3'd3, 1'b1, 24'hFFE000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'hFFE00C, 3'd4, 1'b1, 24'hFFE000, ST_IDLE);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'hFFE00C, 3'd4, 1'b1, 24'hFFE000, ST_IDLE);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hFFE010, 3'd3, 1'b1, 24'hFFE004, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 24'hFFE010, 3'd4, 1'b1, 24'hFFE004, ST_IDLE);
    // redirect coincident with ack and pop, unaligned target
    add_vec(1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 24'hFFE000, 3'd0, 1'b0, 24'h000000, ST_IDLE);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hFFE000, 3'd0, 1'b0, 24'h000000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hFFE004, 3'd1, 1'b1, 24'hFFE000, ST_WAIT);
    add_vec(1'b0, 1'b1, 24'h000103, 1'b1, 1'b0, 24'hFFE004, 3'd0, 1'b0, 24'h000000, ST_IDLE);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h000100, 3'd0, 1'b0, 24'h000000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h000104, 3'd1, 1'b1, 24'h000100, ST_WAIT);
    // redirect near the top of the address space, PC wraps to zero
    add_vec(1'b0, 1'b1, 24'hFFFFF8, 1'b1, 1'b0, 24'h000104, 3'd0, 1'b0, 24'h000000, ST_IDLE);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hFFFFF8, 3'd0, 1'b0, 24'h000000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'hFFFFFC, 3'd1, 1'b1, 24'hFFFFF8, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h000000, 3'd1, 1'b1, 24'hFFFFFC, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h000004, 3'd1, 1'b1, 24'h000000, ST_WAIT);
    add_vec(1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 24'h000008, 3'd1, 1'b1, 24'h000004, ST_WAIT);

    repeat (2) @(negedge clk);
    lat = 0;
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst;
      redirect = vq[i].redir;
      redirect_addr = vq[i].raddr;
      out_ready = vq[i].rdy;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'(vq[i].req));
      check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vq[i].addr));
      check($sformatf("v%0d_level", i), 32'(level), 32'(vq[i].lvl));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].lvl != 3'd0));
      check($sformatf("v%0d_state", i), 32'(state_dbg), 32'(vq[i].st));
      if (vq[i].chk_pc) begin
        check($sformatf("v%0d_out_pc", i), 32'(out_pc), 32'(vq[i].pc));
        check($sformatf("v%0d_out_instr", i), out_instr, mem_word(vq[i].pc));
      end
    end
    redirect = 1'b0;

    // redirect while a slow read is outstanding: old data must be dropped
    begin
      int n;
      logic seen_out;
      lat = 3;
      out_ready = 1'b1;
      do_reset();
      @(negedge clk);
      check("drop_first_req", 32'(mem_req), 32'd1);
      redirect = 1'b1;
      redirect_addr = 24'h000100;
      @(negedge clk);
      redirect = 1'b0;
      check("drop_state", 32'(state_dbg), 32'(ST_DROP));
      check("drop_req_held", 32'(mem_req), 32'd1);
      check("drop_addr_held", 32'(mem_addr), 32'hFFE000);
      check("drop_level", 32'(level), 32'd0);
      n = 0;
      seen_out = 1'b0;
      while (!(mem_req && mem_addr == 24'h000100) && n < 12) begin
        @(negedge clk);
        if (out_valid) seen_out = 1'b1;
        n++;
      end
      check("drop_new_req", 32'(mem_req && mem_addr == 24'h000100), 32'd1);
      check("drop_no_output", 32'(seen_out), 32'd0);
      n = 0;
      while (!out_valid && n < 12) begin
        @(negedge clk);
        n++;
      end
      check("drop_out_valid", 32'(out_valid), 32'd1);
      check("drop_out_pc", 32'(out_pc), 32'h000100);
      check("drop_out_instr", out_instr, mem_word(24'h000100));
    end

    // asynchronous reset while waiting with three entries queued
    lat = 0;
    out_ready = 1'b0;
    do_reset();
    repeat (4) @(negedge clk);
    check("rstmid_level_before", 32'(level), 32'd3);
    check("rstmid_state_before", 32'(state_dbg), 32'(ST_WAIT));
    rst = 1'b1;
    #1;
    check("rstmid_mem_req", 32'(mem_req), 32'd0);
    check("rstmid_level", 32'(level), 32'd0);
    check("rstmid_out_valid", 32'(out_valid), 32'd0);
    check("rstmid_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rstmid_addr", 32'(mem_addr), 32'hFFE000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_restart_req", 32'(mem_req), 32'd1);
    check("rstmid_restart_addr", 32'(mem_addr), 32'hFFE000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the RISC5 pipeline. It holds the fetch PC, issues word reads to the instruction memory over a req/ack handshake, and buffers fetched instructions with their PCs in a DEPTH-entry prefetch queue. The decode stage drains the queue over a valid/ready handshake. A redirect input (branch/jump/trap) flushes the queue and restarts fetching at a new address; a read already in flight is discarded when its ack arrives.

## Interface
- ADDR_WIDTH, 24: width of PC and memory address (byte address).
- DATA_WIDTH, 32: instruction width.
- DEPTH, 4: prefetch queue entries; power of two, 2..16.
- START_ADDR, 24'hFFE000: fetch PC after reset.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  system reset, asynchronous, active-high.
- mem_req  out  1  read request; held until mem_ack.
- mem_addr  out  ADDR_WIDTH  read address, word-aligned, stable while mem_req=1.
- mem_ack  in  1  read complete; mem_data valid this cycle.
- mem_data  in  DATA_WIDTH  read data.
- redirect  in  1  single-cycle request to restart fetching.
- redirect_addr  in  ADDR_WIDTH  new fetch PC; bits [1:0] ignored (forced 0).
- out_valid  out  1  queue head valid.
- out_instr  out  DATA_WIDTH  instruction at queue head.
- out_pc  out  ADDR_WIDTH  PC of instruction at queue head.
- out_ready  in  1  decode accepts head this cycle.
- level  out  log2(DEPTH)+1  number of queued entries.

## Operation
- State machine: IDLE (no request), WAIT (request for current fetch PC outstanding), DROP (request outstanding, result to be discarded). mem_req = (state != IDLE).
- At most one read outstanding. Free slot counted at issue: request issued only when level < DEPTH; push on ack therefore never overflows.
- push = ack in WAIT without redirect; pop = out_valid & out_ready & !redirect; next_level = level + push - pop.
- IDLE: redirect -> stay IDLE, fpc <= redirect_addr. Else if level < DEPTH -> WAIT, mem_addr <= fpc.
- WAIT, no ack, no redirect: hold mem_addr, mem_req.
- WAIT, ack, no redirect: enqueue {mem_addr, mem_data}; fpc <= mem_addr+4; if next_level < DEPTH stay WAIT with mem_addr <= mem_addr+4, else -> IDLE.
- WAIT, redirect, no ack -> DROP; mem_addr held; fpc <= redirect_addr.
- WAIT, redirect and ack same cycle -> data discarded, IDLE, fpc <= redirect_addr.
- DROP: ack -> IDLE, data discarded. Redirect in DROP updates fpc, stays DROP (or IDLE if ack same cycle).
- Any redirect empties the queue (level <= 0) that edge; a same-cycle pop is void.
- Address arithmetic modulo 2^ADDR_WIDTH: 0xFFFFFC + 4 = 0x000000.
- out_instr/out_pc driven from queue head storage; undefined-but-stable content when out_valid=0 is permitted.

## Timing
- Reset values: state IDLE, mem_req 0, mem_addr START_ADDR, fpc START_ADDR, level 0, out_valid 0, queue pointers 0.
- First mem_req at edge 1 after rst deasserts, address START_ADDR.
- Ack -> out_valid: 1 cycle (registered push). Zero-wait memory (ack same cycle as req) sustains 1 instruction/cycle while out_ready=1.
- Full queue, out_ready=0: mem_req deasserts the cycle after the DEPTH-th ack; reasserts the cycle after the first pop.
- Redirect -> first new mem_req: 1 cycle from IDLE/WAIT-with-ack; otherwise 1 cycle after the discarded ack.
- rst mid-transaction: all state to reset values immediately; an in-flight ack after reset is ignored (state IDLE).
- out_valid = (level != 0), registered-equivalent, no combinational path from out_ready.

## Test plan
- Reset release, memory acking same cycle, out_ready=1 -> mem_addr FFE000, FFE004, FFE008 on consecutive cycles; out_pc follows one cycle later; level stays 1.
- out_ready=0, zero-wait memory -> exactly 4 pushes (FFE000..FFE00C), level=4, mem_req=0; one pop -> mem_req=1 next cycle at FFE010.
- Memory with 3-cycle ack latency, redirect to 000100 in first wait cycle -> mem_req stays high at old address until ack, that data never appears at output, next request at 000100, level=0 after redirect.
- redirect coincident with mem_ack and out_ready -> no push, no pop, level=0 next cycle, next request at redirect_addr; redirect_addr=000103 -> fetch at 000100.
- redirect to FFFFF8 -> fetched PCs FFFFF8, FFFFFC, 000000, 000004.
- Assert rst while in WAIT with level=3 -> immediately mem_req=0, level=0, out_valid=0; after release first request at FFE000.
